// File: rtl/i_cache_direct.sv
// Direct-mapped read-only instruction cache: combinational hit path on the fetch port,
// single-line refill from instruction memory through a three-state miss FSM.
module i_cache_direct #(
   parameter int WORD_SIZE   = 16,
   parameter int INDEX_BITS  = 3,
   parameter int OFFSET_BITS = 2
) (
   input  logic                                  Clk,
   input  logic                                  Reset,
   input  logic                                  cpu_readM,
   input  logic [WORD_SIZE-1:0]                  cpu_address,
   output logic [WORD_SIZE-1:0]                  cpu_data,
   output logic                                  cpu_ready,
   input  logic                                  flush,
   output logic                                  mem_readM,
   output logic [WORD_SIZE-1:0]                  mem_address,
   input  logic [WORD_SIZE*(2**OFFSET_BITS)-1:0] mem_data,
   input  logic                                  mem_ready,
   output logic [WORD_SIZE-1:0]                  hit_count,
   output logic [WORD_SIZE-1:0]                  miss_count
);

   localparam int LINES     = 2**INDEX_BITS;
   localparam int LINE_BITS = WORD_SIZE*(2**OFFSET_BITS);
   localparam int TAG_BITS  = WORD_SIZE - INDEX_BITS - OFFSET_BITS;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_REFILL} state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [LINES-1:0]       r_valid;
   logic [TAG_BITS-1:0]    r_tags  [LINES];
   logic [LINE_BITS-1:0]   r_lines [LINES];
   logic [WORD_SIZE-1:0]   r_line_addr;
   logic [WORD_SIZE-1:0]   r_last_data;
   logic [WORD_SIZE-1:0]   r_hit_count;
   logic [WORD_SIZE-1:0]   r_miss_count;

   logic [OFFSET_BITS-1:0] w_offset;
   logic [INDEX_BITS-1:0]  w_index;
   logic [TAG_BITS-1:0]    w_tag;
   logic [INDEX_BITS-1:0]  w_fill_index;
   logic [TAG_BITS-1:0]    w_fill_tag;
   logic [LINE_BITS-1:0]   w_sel_line;
   logic [WORD_SIZE-1:0]   w_word;
   logic                   w_hit;
   logic                   w_miss;
   logic                   w_fill;

   assign w_offset     = cpu_address[OFFSET_BITS-1:0];
   assign w_index      = cpu_address[OFFSET_BITS +: INDEX_BITS];
   assign w_tag        = cpu_address[WORD_SIZE-1 -: TAG_BITS];
   assign w_fill_index = r_line_addr[OFFSET_BITS +: INDEX_BITS];
   assign w_fill_tag   = r_line_addr[WORD_SIZE-1 -: TAG_BITS];
   assign w_sel_line   = r_lines[w_index];
   assign w_word       = w_sel_line[int'(w_offset)*WORD_SIZE +: WORD_SIZE];

   assign w_hit  = !Reset && (r_state == S_IDLE) && cpu_readM
                   && r_valid[w_index] && (r_tags[w_index] == w_tag);
   assign w_miss = (r_state == S_IDLE) && cpu_readM && !w_hit;
   // A response is only accepted while a refill is outstanding.
   assign w_fill = (r_state == S_FETCH) && mem_ready;

   assign cpu_ready   = w_hit;
   assign cpu_data    = Reset ? '0 : (w_hit ? w_word : r_last_data);
   assign mem_readM   = !Reset && (r_state == S_FETCH);
   assign mem_address = r_line_addr;
   assign hit_count   = r_hit_count;
   assign miss_count  = r_miss_count;

   always_comb begin
      // NOTE: default first so every path assigns w_next_state and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_miss) w_next_state = S_FETCH;
         S_FETCH:  if (mem_ready) w_next_state = S_REFILL;
         S_REFILL: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_valid      <= '0;
         r_line_addr  <= '0;
         r_last_data  <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_state <= w_next_state;
         // Flush beats a same-edge refill: the line is left invalid.
         if (flush) begin
            r_valid <= '0;
         end else if (w_fill) begin
            r_valid[w_fill_index] <= 1'b1;
         end
         if (w_miss) begin
            r_line_addr  <= {cpu_address[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            r_miss_count <= r_miss_count + 1'b1;
         end
         if (w_hit) begin
            r_last_data <= w_word;
            r_hit_count <= r_hit_count + 1'b1;
         end
      end
   end

   // NOTE: tag/data arrays are not reset; the valid bits alone gate their use.
   always_ff @(posedge Clk) begin
      if (!Reset && w_fill) begin
         r_tags[w_fill_index]  <= w_fill_tag;
         r_lines[w_fill_index] <= mem_data;
      end
   end

endmodule

// File: doc/i_cache_direct.md
Name: i_cache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined CPU's instruction-fetch port and the instruction memory.
- CPU side: word request with a combinational hit/ready indication. The fetch stage stalls while cpu_ready is low.
- Memory side: line-refill handshake with variable memory latency.
- Keeps hit/miss counters for performance reporting.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- INDEX_BITS, 3, log2 of number of lines (default 8 lines).
- OFFSET_BITS, 2, log2 of words per line (default 4 words = 64-bit line).

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- cpu_readM  input  1  CPU fetch request valid.
- cpu_address  input  WORD_SIZE  word address of instruction.
- cpu_data  output  WORD_SIZE  instruction word; valid when cpu_ready=1.
- cpu_ready  output  1  hit this cycle; CPU may advance.
- flush  input  1  invalidate all lines.
- mem_readM  output  1  line refill request, held until mem_ready.
- mem_address  output  WORD_SIZE  line-aligned address (offset bits zero).
- mem_data  input  WORD_SIZE*(2**OFFSET_BITS)  refill line; word 0 in LSBs.
- mem_ready  input  1  one-cycle pulse: mem_data valid.
- hit_count  output  WORD_SIZE  number of hit cycles.
- miss_count  output  WORD_SIZE  number of misses detected.

Behaviour:
- Address split: offset = addr[OFFSET_BITS-1:0]; index = next INDEX_BITS; tag = remaining upper bits (11 at defaults).
- Storage per line: valid bit, tag, data line.

FSM states:
- IDLE: lookup.
  - hit = cpu_readM & valid[index] & tag match; cpu_ready = hit (combinational, same cycle); cpu_data = selected word.
  - On cpu_readM & ~hit: latch line address; miss_count += 1; go to FETCH.
- FETCH: mem_readM=1; mem_address = latched line address; cpu_ready=0.
  - On mem_ready: write mem_data, latched tag and valid=1 into the latched index; go to REFILL.
- REFILL: cpu_ready=0, mem_readM=0; go to IDLE. The lookup then hits.

Latency:
- Hit: 0 extra cycles.
- Miss: request-to-ready = memory latency (cycles from mem_readM rise to mem_ready) + 2.

Handshake rules:
- mem_readM and mem_address stay stable from FETCH entry until the mem_ready cycle.
- mem_ready outside FETCH is ignored.
- Changes to cpu_address during FETCH/REFILL do not affect the refill. The IDLE lookup uses the address current at that cycle.

Counters:
- hit_count += 1 on each IDLE cycle with hit.
- Both counters wrap modulo 2^WORD_SIZE, with no saturation.

cpu_readM=0:
- cpu_ready=0, no lookup, no counting.
- cpu_data holds the last driven value; don't-care.

Flush:
- Clears all valid bits at the edge.
- In IDLE, it takes priority over a same-cycle hit for the *next* cycle only; the current-cycle hit is still reported.
- In FETCH, the FSM continues.
- In a cycle where the refill write occurs simultaneously (mem_ready in FETCH), flush wins: the line ends invalid and the FSM still goes to REFILL, then IDLE, and misses again.

Reset:
- Takes effect at the edge in any state, including mid-FETCH.
- Valid bits cleared, state IDLE, counters 0, mem_readM=0, mem_address=0, cpu_ready=0 during reset, cpu_data=0.
- Outstanding memory responses after reset are ignored.
- Tag/data arrays need no reset.

Test Plan:
- Cold miss then hit: Reset, cpu_readM=1, addr=0x0005, memory returns line {0x4444,0x3333,0x2222,0x1111} (word3..word0) after 3 cycles -> mem_address=0x0004, cpu_ready rises 5 cycles after request, cpu_data=0x2222; miss_count=1, hit_count=1.
- Spatial hits: after test 1, addresses 0x0004,0x0006,0x0007 on consecutive cycles -> cpu_ready=1 each cycle, data 0x1111,0x3333,0x4444, no mem_readM; hit_count=4.
- Conflict eviction: load 0x0004, then 0x0024 (same index 1, different tag) -> miss, mem_address=0x0024; re-access 0x0004 -> miss again; miss_count=3.
- Flush: after lines loaded, flush=1 for one cycle, then addr 0x0004 -> miss, mem_readM asserted; flush coincident with mem_ready -> one extra miss on the subsequent lookup.
- Reset mid-FETCH: Reset asserted while mem_readM=1 -> next cycle mem_readM=0, counters 0; a late mem_ready pulse does not set any valid bit (next access to same address misses).
- Counter wrap: preload hit_count near 0xFFFF via 0xFFFF hit cycles plus 2 -> hit_count=0x0001.
